// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer for a single-port, 1-cycle-latency word RAM.
// Handles load lane alignment, single-cycle word stores and read-modify-write sub-word stores.
module mem_access_sequencer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            accessSize,
  input  logic [31:0]           address,
  input  logic [31:0]           writeData,
  output logic                  stall,
  output logic [31:0]           alignedData,
  output logic [1:0]            maskLength,
  output logic                  loadValid,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic                  ramWe,
  output logic [31:0]           ramWData,
  input  logic [31:0]           ramRData
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_DONE,
    RMW_MERGE,
    RMW_WRITE
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  size_e                 size_q, size_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [31:0]           merged_q, merged_d;
  logic [31:0]           aligned_q, aligned_d;
  logic [1:0]            mask_q, mask_d;

  size_e                 req_size;
  logic                  req_misaligned;
  logic                  stall_c, load_valid_c, misaligned_c, ram_we_c;
  logic [31:0]           ram_wdata_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;

  // Bits above the RAM word address and below the word boundary are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_WIDTH+2];

  assign req_size       = (accessSize == 2'd3) ? SZ_WORD : size_e'(accessSize);
  assign req_misaligned = ((req_size == SZ_WORD) && (address[1:0] != 2'b00)) ||
                          ((req_size == SZ_HALF) && address[0]);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    aligned_d    = aligned_q;
    mask_d       = mask_q;
    stall_c      = 1'b0;
    load_valid_c = 1'b0;
    misaligned_c = 1'b0;
    ram_we_c     = 1'b0;
    ram_wdata_c  = '0;
    ram_addr_c   = addr_q;

    unique case (state_q)
      IDLE: begin
        ram_addr_c = address[ADDR_WIDTH+1:2];
        if (memRead || memWrite) begin
          if (req_misaligned) begin
            misaligned_c = 1'b1;
          end else begin
            addr_d  = address[ADDR_WIDTH+1:2];
            off_d   = address[1:0];
            size_d  = req_size;
            wdata_d = writeData[15:0];
            // A simultaneous read and write is executed as a load only.
            if (memRead) begin
              stall_c = 1'b1;
              state_d = LOAD_WAIT;
            end else if (req_size == SZ_WORD) begin
              ram_we_c    = 1'b1;
              ram_wdata_c = writeData;
            end else begin
              stall_c = 1'b1;
              state_d = RMW_MERGE;
            end
          end
        end
      end

      LOAD_WAIT: begin
        stall_c   = 1'b1;
        aligned_d = ramRData >> {off_q, 3'b000};
        mask_d    = size_q;
        state_d   = LOAD_DONE;
      end

      LOAD_DONE: begin
        load_valid_c = 1'b1;
        state_d      = IDLE;
      end

      RMW_MERGE: begin
        stall_c  = 1'b1;
        merged_d = ramRData;
        if (size_q == SZ_BYTE) begin
          merged_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
          merged_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
        state_d = RMW_WRITE;
      end

      RMW_WRITE: begin
        ram_we_c    = 1'b1;
        ram_wdata_c = merged_q;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      size_q    <= SZ_WORD;
      wdata_q   <= '0;
      merged_q  <= '0;
      aligned_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      merged_q  <= merged_d;
      aligned_q <= aligned_d;
      mask_q    <= mask_d;
    end
  end

  // Outputs are forced low for the whole reset cycle, which also blocks an aborted RMW write.
  assign stall       = reset ? 1'b0 : stall_c;
  assign loadValid   = reset ? 1'b0 : load_valid_c;
  assign misaligned  = reset ? 1'b0 : misaligned_c;
  assign ramWe       = reset ? 1'b0 : ram_we_c;
  assign ramWData    = reset ? '0   : ram_wdata_c;
  assign ramAddr     = reset ? '0   : ram_addr_c;
  assign alignedData = reset ? '0   : aligned_q;
  assign maskLength  = reset ? '0   : mask_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: a behavioural RAM plus a word-array reference
// model, directed scenarios and a randomized access stream.
module tb_mem_access_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [1:0]  accessSize;
  logic [31:0] address, writeData;
  logic        stall, loadValid, misaligned, ramWe;
  logic [31:0] alignedData, ramWData, ramRData;
  logic [1:0]  maskLength;
  logic [9:0]  ramAddr;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        init_we;
  logic [9:0]  init_addr;
  logic [31:0] init_data;
  logic [31:0] last_aligned;
  logic [1:0]  last_mask;
  bit          we_seen_in_abort;

  mem_access_sequencer #(.ADDR_WIDTH(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .accessSize  (accessSize),
    .address     (address),
    .writeData   (writeData),
    .stall       (stall),
    .alignedData (alignedData),
    .maskLength  (maskLength),
    .loadValid   (loadValid),
    .misaligned  (misaligned),
    .ramAddr     (ramAddr),
    .ramWe       (ramWe),
    .ramWData    (ramWData),
    .ramRData    (ramRData)
  );

  always #5 clock = ~clock;

  // Single-port RAM, read data one cycle after the address.
  always @(posedge clock) begin
    if (init_we) ram[init_addr] <= init_data;
    else if (ramWe) ram[ramAddr] <= ramWData;
    ramRData <= ram[ramAddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One MEM-stage request, checked cycle by cycle against the reference model.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [1:0]  eff, off;
    logic [9:0]  idx;
    logic        mis, is_load, is_wstore, is_sstore;
    logic        exp_stall, exp_we, exp_lv, exp_mis;
    logic [31:0] exp_data, lane_mask, merged, exp_wdata;
    int          len;
    eff       = (sz == 2'd3) ? 2'd0 : sz;
    off       = a[1:0];
    idx       = a[11:2];
    mis       = (rd || wr) && (((eff == 2'd0) && (off != 2'd0)) || ((eff == 2'd1) && off[0]));
    is_load   = rd && !mis;
    is_wstore = wr && !rd && !mis && (eff == 2'd0);
    is_sstore = wr && !rd && !mis && (eff != 2'd0);
    len       = (is_load || is_sstore) ? 3 : 1;
    exp_data  = ref_mem[idx] >> (8 * off);
    lane_mask = ((eff == 2'd2) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
    merged    = (ref_mem[idx] & ~lane_mask) | ((wd << (8 * off)) & lane_mask);
    exp_wdata = is_wstore ? wd : merged;

    memRead = rd; memWrite = wr; accessSize = sz; address = a; writeData = wd;
    for (int c = 0; c < len; c++) begin
      @(negedge clock);
      exp_stall = (c < len - 1);
      exp_we    = (is_wstore && c == 0) || (is_sstore && c == 2);
      exp_lv    = is_load && (c == 2);
      exp_mis   = mis && (c == 0);
      total++;
      if (stall !== exp_stall) begin
        bad++; $display("FAIL %s stall c%0d: got %b want %b", tag, c, stall, exp_stall);
      end
      total++;
      if (ramWe !== exp_we) begin
        bad++; $display("FAIL %s ramWe c%0d: got %b want %b", tag, c, ramWe, exp_we);
      end
      total++;
      if (loadValid !== exp_lv) begin
        bad++; $display("FAIL %s loadValid c%0d: got %b want %b", tag, c, loadValid, exp_lv);
      end
      total++;
      if (misaligned !== exp_mis) begin
        bad++; $display("FAIL %s misaligned c%0d: got %b want %b", tag, c, misaligned, exp_mis);
      end
      if (rd || wr) begin
        total++;
        if (ramAddr !== idx) begin
          bad++; $display("FAIL %s ramAddr c%0d: got %h want %h", tag, c, ramAddr, idx);
        end
      end
      if (exp_we) begin
        total++;
        if (ramWData !== exp_wdata) begin
          bad++; $display("FAIL %s ramWData c%0d: got %h want %h", tag, c, ramWData, exp_wdata);
        end
      end
      if (c == 0) begin
        total++;
        if (alignedData !== last_aligned || maskLength !== last_mask) begin
          bad++; $display("FAIL %s held load result: got %h/%0d want %h/%0d", tag,
                          alignedData, maskLength, last_aligned, last_mask);
        end
      end
      if (exp_lv) begin
        total++;
        if (alignedData !== exp_data || maskLength !== eff) begin
          bad++; $display("FAIL %s load result: got %h/%0d want %h/%0d", tag,
                          alignedData, maskLength, exp_data, eff);
        end
        last_aligned = exp_data;
        last_mask    = eff;
      end
      @(posedge clock); #1;
    end
    if (is_wstore) ref_mem[idx] = wd;
    if (is_sstore) ref_mem[idx] = merged;
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    memRead = 1'b0; memWrite = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      total++;
      if (stall !== 1'b0 || ramWe !== 1'b0 || loadValid !== 1'b0 || misaligned !== 1'b0) begin
        bad++; $display("FAIL %s idle c%0d: got stall=%b we=%b lv=%b mis=%b want all 0",
                        tag, c, stall, ramWe, loadValid, misaligned);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if (stall !== 1'b0 || loadValid !== 1'b0 || misaligned !== 1'b0 || ramWe !== 1'b0 ||
        ramWData !== 32'h0 || ramAddr !== 10'h0 || alignedData !== 32'h0 || maskLength !== 2'd0) begin
      bad++; $display("FAIL %s outputs: got stall=%b lv=%b mis=%b we=%b wd=%h ra=%h ad=%h ml=%0d want all 0",
                      tag, stall, loadValid, misaligned, ramWe, ramWData, ramAddr, alignedData, maskLength);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; memRead = 1'b1; memWrite = 1'b0; accessSize = 2'd2;
    address = 32'h13; writeData = 32'h0; init_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      init_we = 1'b1; init_addr = 10'(i); init_data = $urandom;
      ref_mem[i] = init_data;
    end
    @(posedge clock); #1;
    init_we = 1'b0;
    @(negedge clock);
    check_zero_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0; memRead = 1'b0;
    last_aligned = 32'h0; last_mask = 2'd0;
    idle_cycles(2, "after_reset");
  endtask

  task automatic test_word_store_load();
    do_access(1'b0, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, "word_store");
    do_access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, "word_load");
    total++;
    if (alignedData !== 32'hDEADBEEF || maskLength !== 2'd0) begin
      bad++; $display("FAIL word_load const: got %h/%0d want deadbeef/0", alignedData, maskLength);
    end
  endtask

  task automatic test_byte_load();
    do_access(1'b1, 1'b0, 2'd2, 32'h13, 32'h0, "byte_load");
    total++;
    if (alignedData !== 32'h000000DE || maskLength !== 2'd2) begin
      bad++; $display("FAIL byte_load const: got %h/%0d want 000000de/2", alignedData, maskLength);
    end
  endtask

  task automatic test_half_store();
    do_access(1'b0, 1'b1, 2'd1, 32'h12, 32'h0000_1234, "half_store");
    do_access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, "half_reload");
    total++;
    if (alignedData !== 32'h1234BEEF) begin
      bad++; $display("FAIL half_reload const: got %h want 1234beef", alignedData);
    end
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 2'd0, 32'h21, 32'h0, "mis_word_load");
    do_access(1'b0, 1'b1, 2'd1, 32'h23, 32'h5555_AAAA, "mis_half_store");
    do_access(1'b0, 1'b1, 2'd3, 32'h22, 32'h7777_7777, "mis_size3_store");
    do_access(1'b1, 1'b0, 2'd0, 32'h20, 32'h0, "mis_reload");
  endtask

  task automatic test_conflict_wrap();
    do_access(1'b1, 1'b1, 2'd0, 32'h10, 32'hCAFEF00D, "conflict");
    total++;
    if (alignedData !== 32'h1234BEEF) begin
      bad++; $display("FAIL conflict const: got %h want 1234beef", alignedData);
    end
    do_access(1'b0, 1'b1, 2'd0, 32'h0000_1000, 32'hA5A5_0F0F, "wrap_store");
    do_access(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "wrap_reload");
    total++;
    if (alignedData !== 32'hA5A5_0F0F) begin
      bad++; $display("FAIL wrap_reload const: got %h want a5a50f0f", alignedData);
    end
  endtask

  task automatic test_reset_mid_rmw();
    do_access(1'b0, 1'b1, 2'd0, 32'h08, 32'h1122_3344, "rmw_abort_prep");
    memWrite = 1'b1; accessSize = 2'd2; address = 32'h08; writeData = 32'h0000_00AB;
    @(negedge clock);
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL rmw_abort start stall: got %b want 1", stall);
    end
    @(posedge clock); #1;
    reset = 1'b1; memWrite = 1'b0;
    we_seen_in_abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check_zero_outputs("rmw_abort_in_reset");
      @(posedge clock); #1;
    end
    reset = 1'b0;
    last_aligned = 32'h0; last_mask = 2'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (ramWe !== 1'b0 || stall !== 1'b0) we_seen_in_abort = 1'b1;
      @(posedge clock); #1;
    end
    total++;
    if (we_seen_in_abort) begin
      bad++; $display("FAIL rmw_abort after reset: got write/stall activity want none");
    end
    do_access(1'b1, 1'b0, 2'd0, 32'h08, 32'h0, "rmw_abort_reload");
    total++;
    if (alignedData !== 32'h1122_3344) begin
      bad++; $display("FAIL rmw_abort reload const: got %h want 11223344", alignedData);
    end
  endtask

  task automatic test_random(input int n);
    int          kind;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if (kind <= 3)      do_access(1'b1, 1'b0, 2'($urandom_range(0, 3)), a, $urandom, "rand_load");
      else if (kind <= 7) do_access(1'b0, 1'b1, 2'($urandom_range(0, 3)), a, $urandom, "rand_store");
      else if (kind == 8) do_access(1'b1, 1'b1, 2'($urandom_range(0, 3)), a, $urandom, "rand_both");
      else                idle_cycles(1, "rand_idle");
    end
  endtask

  task automatic test_ram_contents();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (ram[i] !== ref_mem[i]) begin
        bad++; $display("FAIL ram_word[%0d]: got %h want %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_conflict_wrap();
    test_reset_mid_rmw();
    test_random(300);
    idle_cycles(2, "drain");
    test_ram_contents();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
